// File: rtl/reg_mux_arbiter_if.sv
// Bundle between the four register-source requesters/sink and the arbiter.
// The master side drives requests, data and sink readiness; the slave is the arbiter.
interface reg_mux_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]       req;
  logic [3:0]       lock;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [WIDTH-1:0] in_3;
  logic             sink_ready;
  logic [3:0]       gnt;
  logic [1:0]       mux_sel;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;

  modport master (
    output req, lock, in_0, in_1, in_2, in_3, sink_ready,
    input  gnt, mux_sel, data_out, data_valid, busy
  );

  modport slave (
    input  req, lock, in_0, in_1, in_2, in_3, sink_ready,
    output gnt, mux_sel, data_out, data_valid, busy
  );
endinterface

// File: rtl/reg_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 register-source mux among four requesters,
// with registered data capture and optional locked bursts of up to MAX_BURST transfers.
module reg_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  reg_mux_arbiter_if.slave bus
);
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r, state_n;
  logic [3:0]       gnt_r, gnt_n;
  logic [1:0]       mux_sel_r, mux_sel_n;
  logic [1:0]       ptr_r, ptr_n;
  logic [CNT_W-1:0] burst_cnt_r, burst_n;
  logic [WIDTH-1:0] data_out_r, data_out_n;
  logic             data_valid_r, data_valid_n;
  logic             busy_r;
  logic [1:0]       winner_s;
  logic [WIDTH-1:0] sel_data_s;

  // First set request after the last grantee, wrapping modulo 4.
  function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + k[1:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  assign winner_s = pick_winner(bus.req, ptr_r);

  // The shared 4:1 source mux steered by the current grantee.
  always_comb begin
    sel_data_s = bus.in_0;
    case (mux_sel_r)
      2'd0:    sel_data_s = bus.in_0;
      2'd1:    sel_data_s = bus.in_1;
      2'd2:    sel_data_s = bus.in_2;
      2'd3:    sel_data_s = bus.in_3;
      default: sel_data_s = bus.in_0;
    endcase
  end

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_n      = state_r;
    gnt_n        = gnt_r;
    mux_sel_n    = mux_sel_r;
    ptr_n        = ptr_r;
    burst_n      = burst_cnt_r;
    data_out_n   = data_out_r;
    data_valid_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (|bus.req) begin
          state_n   = GRANT;
          gnt_n     = 4'b0001 << winner_s;
          mux_sel_n = winner_s;
          burst_n   = {CNT_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[mux_sel_r]) begin
          state_n = IDLE;
          gnt_n   = 4'b0000;
          ptr_n   = mux_sel_r;
          burst_n = {CNT_W{1'b0}};
        end else if (!bus.sink_ready) begin
          state_n = GRANT;
        end else begin
          data_out_n   = sel_data_s;
          data_valid_n = 1'b1;
          // LOCK is only looked at here, so a mid-burst change applies at the next transfer.
          if (bus.lock[mux_sel_r] && (burst_cnt_r < BURST_LAST)) begin
            burst_n = burst_cnt_r + CNT_W'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            ptr_n   = mux_sel_r;
            burst_n = {CNT_W{1'b0}};
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      gnt_r        <= 4'b0000;
      mux_sel_r    <= 2'd0;
      ptr_r        <= 2'd3;
      burst_cnt_r  <= {CNT_W{1'b0}};
      data_out_r   <= {WIDTH{1'b0}};
      data_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      gnt_r        <= gnt_n;
      mux_sel_r    <= mux_sel_n;
      ptr_r        <= ptr_n;
      burst_cnt_r  <= burst_n;
      data_out_r   <= data_out_n;
      data_valid_r <= data_valid_n;
      busy_r       <= (state_n == GRANT);
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.mux_sel    = mux_sel_r;
  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_reg_mux_arbiter.sv
// Self-checking bench for reg_mux_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_reg_mux_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst_n;

  reg_mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

  reg_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner = -1 when nobody holds the grant.
  int         m_owner = -1;
  int         m_ptr   = 3;
  int         m_burst = 0;
  logic [7:0] m_dout  = 8'h00;
  logic       m_dv    = 1'b0;
  logic [1:0] m_sel   = 2'd0;

  function automatic logic [7:0] in_of(int i);
    case (i)
      0:       return bus.in_0;
      1:       return bus.in_1;
      2:       return bus.in_2;
      default: return bus.in_3;
    endcase
  endfunction

  // Advance one clock and apply the arbitration rules to the model.
  task automatic step();
    int j;
    @(posedge clk);
    m_dv = 1'b0;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 3; m_burst = 0; m_dout = 8'h00; m_sel = 2'd0;
    end else if (m_owner < 0) begin
      if (bus.req != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          j = (m_ptr + k) % 4;
          if (bus.req[j] && m_owner < 0) m_owner = j;
        end
        m_sel   = m_owner[1:0];
        m_burst = 0;
      end
    end else if (!bus.req[m_owner]) begin
      m_ptr   = m_owner;
      m_owner = -1;
    end else if (bus.sink_ready) begin
      m_dout  = in_of(m_owner);
      m_dv    = 1'b1;
      m_burst = m_burst + 1;
      if (!(bus.lock[m_owner] && m_burst < MAX_BURST)) begin
        m_ptr   = m_owner;
        m_owner = -1;
        m_burst = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 4'hF; bus.lock = 4'h0; bus.sink_ready = 1'b1;
    bus.in_0 = 8'h11; bus.in_1 = 8'h22; bus.in_2 = 8'h33; bus.in_3 = 8'h44;
    repeat (2) begin
      step();
      vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
      vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dv got=%b exp=0", bus.data_valid); end
      vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%h exp=00", bus.data_out); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      vectors++; if (bus.mux_sel !== 2'd0) begin miscompares++; $display("FAIL reset_sel got=%0d exp=0", bus.mux_sel); end
    end
    rst_n = 1'b1; bus.req = 4'h0;
    step();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL idle_gnt got=%b exp=0000", bus.gnt); end
  endtask

  task automatic test_single();
    bus.req = 4'b0100; bus.in_2 = 8'hA5; bus.sink_ready = 1'b1; bus.lock = 4'h0;
    step();
    vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL single_gnt got=%b exp=0100", bus.gnt); end
    vectors++; if (bus.mux_sel !== 2'd2) begin miscompares++; $display("FAIL single_sel got=%0d exp=2", bus.mux_sel); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    step();
    vectors++; if (bus.data_out !== 8'hA5) begin miscompares++; $display("FAIL single_dout got=%h exp=a5", bus.data_out); end
    vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL single_dv got=%b exp=1", bus.data_valid); end
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL single_gnt_off got=%b exp=0000", bus.gnt); end
    bus.req = 4'b0000;
    step();
    vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL single_dv_pulse got=%b exp=0", bus.data_valid); end
    vectors++; if (bus.data_out !== 8'hA5) begin miscompares++; $display("FAIL single_dout_hold got=%h exp=a5", bus.data_out); end
  endtask

  task automatic test_round_robin();
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.req = 4'hF; bus.lock = 4'h0; bus.sink_ready = 1'b1;
    bus.in_0 = 8'h10; bus.in_1 = 8'h11; bus.in_2 = 8'h12; bus.in_3 = 8'h13;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << order[g];
      exp_d = 8'(16 + order[g]);
      step();
      vectors++; if (bus.gnt !== exp_g) begin miscompares++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", g, bus.gnt, exp_g); end
      vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL rr_dv_gap[%0d] got=%b exp=0", g, bus.data_valid); end
      step();
      vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL rr_dv[%0d] got=%b exp=1", g, bus.data_valid); end
      vectors++; if (bus.data_out !== exp_d) begin miscompares++; $display("FAIL rr_dout[%0d] got=%h exp=%h", g, bus.data_out, exp_d); end
      vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL rr_idle[%0d] got=%b exp=0000", g, bus.gnt); end
    end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_burst();
    logic [3:0] exp_g;
    bus.req = 4'b0110; bus.lock = 4'b0010; bus.sink_ready = 1'b1; bus.in_1 = 8'h01; bus.in_2 = 8'h5A;
    step();
    vectors++; if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL burst_gnt got=%b exp=0010", bus.gnt); end
    for (int k = 1; k <= 4; k++) begin
      bus.in_1 = 8'(k);
      exp_g = (k < 4) ? 4'b0010 : 4'b0000;
      step();
      vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL burst_dv[%0d] got=%b exp=1", k, bus.data_valid); end
      vectors++; if (bus.data_out !== 8'(k)) begin miscompares++; $display("FAIL burst_dout[%0d] got=%h exp=%h", k, bus.data_out, 8'(k)); end
      vectors++; if (bus.gnt !== exp_g) begin miscompares++; $display("FAIL burst_hold[%0d] got=%b exp=%b", k, bus.gnt, exp_g); end
    end
    bus.req = 4'b0100; bus.lock = 4'h0;
    step();
    vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL burst_next got=%b exp=0100", bus.gnt); end
    vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL burst_end_dv got=%b exp=0", bus.data_valid); end
    step();
    vectors++; if (bus.data_out !== 8'h5A) begin miscompares++; $display("FAIL burst_next_dout got=%h exp=5a", bus.data_out); end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_stall();
    bus.req = 4'b1000; bus.in_3 = 8'h3C; bus.sink_ready = 1'b0;
    step();
    vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL stall_gnt got=%b exp=1000", bus.gnt); end
    repeat (3) begin
      step();
      vectors++; if (bus.gnt !== 4'b1000) begin miscompares++; $display("FAIL stall_hold got=%b exp=1000", bus.gnt); end
      vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL stall_dv got=%b exp=0", bus.data_valid); end
    end
    bus.sink_ready = 1'b1;
    step();
    vectors++; if (bus.data_out !== 8'h3C) begin miscompares++; $display("FAIL stall_dout got=%h exp=3c", bus.data_out); end
    vectors++; if (bus.data_valid !== 1'b1) begin miscompares++; $display("FAIL stall_release got=%b exp=1", bus.data_valid); end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_abort();
    bus.req = 4'b0010; bus.sink_ready = 1'b1; bus.in_2 = 8'hC7;
    step();
    vectors++; if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL abort_gnt got=%b exp=0010", bus.gnt); end
    bus.req = 4'b0101;
    step();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL abort_drop got=%b exp=0000", bus.gnt); end
    vectors++; if (bus.data_valid !== 1'b0) begin miscompares++; $display("FAIL abort_dv got=%b exp=0", bus.data_valid); end
    step();
    vectors++; if (bus.gnt !== 4'b0100) begin miscompares++; $display("FAIL abort_next got=%b exp=0100", bus.gnt); end
    step();
    vectors++; if (bus.data_out !== 8'hC7) begin miscompares++; $display("FAIL abort_next_dout got=%h exp=c7", bus.data_out); end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    bus.req = 4'b0010; bus.lock = 4'b0010; bus.sink_ready = 1'b1; bus.in_1 = 8'h77; bus.in_0 = 8'h9E;
    step();
    step();
    vectors++; if (bus.data_out !== 8'h77) begin miscompares++; $display("FAIL mid_dout got=%h exp=77", bus.data_out); end
    vectors++; if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL mid_locked got=%b exp=0010", bus.gnt); end
    rst_n = 1'b0;
    step();
    vectors++; if (bus.gnt !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_gnt got=%b exp=0000", bus.gnt); end
    vectors++; if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL mid_rst_dout got=%h exp=00", bus.data_out); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.mux_sel !== 2'd0) begin miscompares++; $display("FAIL mid_rst_sel got=%0d exp=0", bus.mux_sel); end
    rst_n = 1'b1; bus.req = 4'b0011; bus.lock = 4'h0;
    step();
    vectors++; if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL mid_regrant got=%b exp=0001", bus.gnt); end
    step();
    vectors++; if (bus.data_out !== 8'h9E) begin miscompares++; $display("FAIL mid_regrant_dout got=%h exp=9e", bus.data_out); end
    bus.req = 4'h0;
    step();
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.lock       = 4'($urandom_range(0, 15));
      bus.in_0       = 8'($urandom_range(0, 255));
      bus.in_1       = 8'($urandom_range(0, 255));
      bus.in_2       = 8'($urandom_range(0, 255));
      bus.in_3       = 8'($urandom_range(0, 255));
      bus.sink_ready = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 79) != 0);
      step();
      exp_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      vectors++; if (bus.gnt !== exp_g) begin miscompares++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_g); end
      vectors++; if (bus.mux_sel !== m_sel) begin miscompares++; $display("FAIL rnd_sel c=%0d got=%0d exp=%0d", c, bus.mux_sel, m_sel); end
      vectors++; if (bus.data_valid !== m_dv) begin miscompares++; $display("FAIL rnd_dv c=%0d got=%b exp=%b", c, bus.data_valid, m_dv); end
      vectors++; if (bus.data_out !== m_dout) begin miscompares++; $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, bus.data_out, m_dout); end
      vectors++; if (bus.busy !== (m_owner >= 0)) begin miscompares++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy, (m_owner >= 0)); end
    end
  endtask

  initial begin
    rst_n = 1'b0; bus.req = 4'h0; bus.lock = 4'h0; bus.sink_ready = 1'b0;
    bus.in_0 = 8'h00; bus.in_1 = 8'h00; bus.in_2 = 8'h00; bus.in_3 = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_stall();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
